// File: rtl/cobalt_pkg.sv
// Shared cobalt core definitions: CDB geometry, execution-queue indices and
// the round-robin wrap helper.
package cobalt_pkg;

    localparam int NUM_SRC = 4;
    localparam int TAG_W   = 6;
    localparam int DATA_W  = 32;

    typedef enum logic [1:0] {
        SRC_INT = 2'd0,
        SRC_LS  = 2'd1,
        SRC_MUL = 2'd2,
        SRC_DIV = 2'd3
    } src_id_e;

    // Folds an index in [0, 2n-2] back into [0, n-1].
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping from N-1 back to 0.
module rr_pick
    import cobalt_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int off = 0; off < N; off++) begin
            j = rr_wrap(int'(ptr) + off, N);
            if (!any && req[j]) begin
                grant[j] = 1'b1;
                idx      = PTR_W'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one hold buffer per execution queue, round-robin
// grant, registered single-result-per-cycle broadcast.
module cdb_arbiter
    import cobalt_pkg::*;
#(
    parameter int NUM_SRC = cobalt_pkg::NUM_SRC,
    parameter int TAG_W   = cobalt_pkg::TAG_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC-1:0]        src_branch,
    input  logic [NUM_SRC-1:0]        src_branch_taken,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic                      cdb_valid,
    output logic                      cdb_branch,
    output logic                      cdb_branch_taken
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] hold_valid;
    logic [DATA_W-1:0]  hold_data [NUM_SRC];
    logic [TAG_W-1:0]   hold_tag  [NUM_SRC];
    logic [NUM_SRC-1:0] hold_branch;
    logic [NUM_SRC-1:0] hold_taken;
    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] xfer;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_any;

    rr_pick #(
        .N     (NUM_SRC),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (hold_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    // A buffer being drained this cycle can refill on the same edge.
    assign src_ready = (~hold_valid | grant) & {NUM_SRC{~flush}};
    assign xfer      = src_valid & src_ready;

    // Stage p0: hold buffer payload
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (xfer[i]) begin
                hold_data[i]   <= src_data[DATA_W*i +: DATA_W];
                hold_tag[i]    <= src_tag[TAG_W*i +: TAG_W];
                hold_branch[i] <= src_branch[i];
                hold_taken[i]  <= src_branch_taken[i];
            end
        end
    end

    // Stage p1: broadcast register and arbitration state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid       <= '0;
            rr_ptr           <= '0;
            cdb_valid        <= 1'b0;
            cdb_branch       <= 1'b0;
            cdb_branch_taken <= 1'b0;
            cdb_data         <= '0;
            cdb_tag          <= '0;
        end else if (flush) begin
            hold_valid       <= '0;
            cdb_valid        <= 1'b0;
            cdb_branch       <= 1'b0;
            cdb_branch_taken <= 1'b0;
        end else begin
            hold_valid <= (hold_valid & ~grant) | xfer;
            if (gnt_any) begin
                cdb_valid        <= 1'b1;
                cdb_data         <= hold_data[gnt_idx];
                cdb_tag          <= hold_tag[gnt_idx];
                cdb_branch       <= hold_branch[gnt_idx];
                cdb_branch_taken <= hold_branch[gnt_idx] & hold_taken[gnt_idx];
                rr_ptr           <= PTR_W'(rr_wrap(int'(gnt_idx) + 1, NUM_SRC));
            end else begin
                cdb_valid        <= 1'b0;
                cdb_branch       <= 1'b0;
                cdb_branch_taken <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed stimulus pushes expected
// broadcasts, a negedge monitor pops and compares each CDB result.
module tb_cdb_arbiter;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [127:0] src_data;
    logic [23:0]  src_tag;
    logic [3:0]   src_valid;
    logic [3:0]   src_branch;
    logic [3:0]   src_branch_taken;
    logic [3:0]   src_ready;
    logic [31:0]  cdb_data;
    logic [5:0]   cdb_tag;
    logic         cdb_valid;
    logic         cdb_branch;
    logic         cdb_branch_taken;

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] data;
        logic        br;
        logic        tk;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    cdb_arbiter #(
        .NUM_SRC (4),
        .TAG_W   (6)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .src_data         (src_data),
        .src_tag          (src_tag),
        .src_valid        (src_valid),
        .src_branch       (src_branch),
        .src_branch_taken (src_branch_taken),
        .src_ready        (src_ready),
        .cdb_data         (cdb_data),
        .cdb_tag          (cdb_tag),
        .cdb_valid        (cdb_valid),
        .cdb_branch       (cdb_branch),
        .cdb_branch_taken (cdb_branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic [31:0] d, input logic [5:0] t,
                           input logic br, input logic tk);
        src_data[32*s +: 32]  = d;
        src_tag[6*s +: 6]     = t;
        src_branch[s]         = br;
        src_branch_taken[s]   = tk;
        src_valid[s]          = 1'b1;
    endtask

    task automatic push(input logic [5:0] t, input logic [31:0] d, input logic br, input logic tk);
        exp_t e;
        e.tag  = t;
        e.data = d;
        e.br   = br;
        e.tk   = tk;
        exp_q.push_back(e);
    endtask

    // Monitor: every broadcast must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && cdb_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL cdb_unexpected: got tag %0h data %0h expected no broadcast",
                         cdb_tag, cdb_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("cdb_tag", 64'(cdb_tag), 64'(mon_e.tag));
                chk("cdb_data", 64'(cdb_data), 64'(mon_e.data));
                chk("cdb_branch", 64'(cdb_branch), 64'(mon_e.br));
                chk("cdb_branch_taken", 64'(cdb_branch_taken), 64'(mon_e.tk));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   sent [2];
        int   wait_c [2];
        int   max_wait;
        logic rdy [2];
        logic vld [2];

        rst = 1'b0;
        flush = 1'b0;
        src_data = '0;
        src_tag = '0;
        src_valid = '0;
        src_branch = '0;
        src_branch_taken = '0;

        // Reset state, checked before any clock edge.
        #1 rst = 1'b1;
        #2;
        chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("rst_cdb_data", 64'(cdb_data), 64'd0);
        chk("rst_cdb_tag", 64'(cdb_tag), 64'd0);
        chk("rst_cdb_branch", 64'({cdb_branch, cdb_branch_taken}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk("post_rst_ready", 64'(src_ready), 64'hF);
        tick();

        // Single source 3: one pulse two edges later.
        set_src(3, 32'h0000_00A5, 6'h12, 1'b0, 1'b0);
        push(6'h12, 32'h0000_00A5, 1'b0, 1'b0);
        chk("single_ready_pre", 64'(src_ready[3]), 64'd1);
        tick();
        chk("single_ready_post", 64'(src_ready[3]), 64'd1);
        src_valid = '0;
        chk("single_no_early", 64'(cdb_valid), 64'd0);
        tick();
        chk("single_valid", 64'(cdb_valid), 64'd1);
        tick();
        chk("single_one_pulse", 64'(cdb_valid), 64'd0);
        tick();

        // All four together, pointer at 0: tags 1,2,3,4 back to back.
        for (int i = 0; i < 4; i++) begin
            set_src(i, 32'hD000_0000 + 32'(i), 6'(i + 1), 1'b0, 1'b0);
            push(6'(i + 1), 32'hD000_0000 + 32'(i), 1'b0, 1'b0);
        end
        tick();
        src_valid = '0;
        chk("all4_ready_blocked", 64'(src_ready), 64'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("all4_back_to_back", 64'(cdb_valid), 64'd1);
        end
        tick();
        chk("all4_done", 64'(cdb_valid), 64'd0);

        // Source 2 streaming: one result per cycle, no bubble.
        for (int n = 0; n < 8; n++) begin
            set_src(2, 32'hC0DE_0000 + 32'(n), 6'(10 + n), 1'b0, 1'b0);
            push(6'(10 + n), 32'hC0DE_0000 + 32'(n), 1'b0, 1'b0);
            chk("stream_ready", 64'(src_ready[2]), 64'd1);
            tick();
            if (n >= 1) chk("stream_valid", 64'(cdb_valid), 64'd1);
        end
        src_valid = '0;
        tick();
        chk("stream_last", 64'(cdb_valid), 64'd1);
        repeat (2) tick();

        // Fairness: sources 0 and 1 both always offering, four results each.
        for (int n = 0; n < 4; n++) begin
            push(6'h20 + 6'(n), 32'h0000_A000 + 32'(n), 1'b0, 1'b0);
            push(6'h30 + 6'(n), 32'h0000_B000 + 32'(n), 1'b0, 1'b0);
        end
        sent[0] = 0; sent[1] = 0;
        wait_c[0] = 0; wait_c[1] = 0;
        max_wait = 0;
        for (int cyc = 0; cyc < 40 && (sent[0] < 4 || sent[1] < 4); cyc++) begin
            for (int s = 0; s < 2; s++) begin
                vld[s] = (sent[s] < 4);
                if (vld[s])
                    set_src(s, (s == 0 ? 32'h0000_A000 : 32'h0000_B000) + 32'(sent[s]),
                            (s == 0 ? 6'h20 : 6'h30) + 6'(sent[s]), 1'b0, 1'b0);
                else
                    src_valid[s] = 1'b0;
                rdy[s] = src_ready[s];
            end
            tick();
            for (int s = 0; s < 2; s++) begin
                if (vld[s] && rdy[s]) begin
                    sent[s]++;
                    wait_c[s] = 0;
                end else if (vld[s]) begin
                    wait_c[s]++;
                    if (wait_c[s] > max_wait) max_wait = wait_c[s];
                end
            end
        end
        src_valid = '0;
        chk("fair_sent0", 64'(sent[0]), 64'd4);
        chk("fair_sent1", 64'(sent[1]), 64'd4);
        chk("fair_wait_le2", 64'(max_wait <= 2), 64'd1);
        repeat (4) tick();

        // Flush with sources 0 and 3 holding results; source 2 offers during flush.
        set_src(0, 32'h0BAD_0000, 6'h3A, 1'b0, 1'b0);
        set_src(3, 32'h0BAD_0003, 6'h3B, 1'b0, 1'b0);
        tick();
        src_valid = '0;
        flush = 1'b1;
        set_src(2, 32'h0BAD_0002, 6'h3C, 1'b0, 1'b0);
        #1;
        chk("flush_ready_low", 64'(src_ready), 64'h0);
        tick();
        chk("flush_cdb_valid", 64'(cdb_valid), 64'd0);
        flush = 1'b0;
        src_valid = '0;
        #1;
        chk("flush_ready_after", 64'(src_ready), 64'hF);
        repeat (4) tick();

        // Branch outcome on source 1, then a non-branch with taken set.
        set_src(1, 32'h0000_B7A0, 6'h05, 1'b1, 1'b1);
        push(6'h05, 32'h0000_B7A0, 1'b1, 1'b1);
        tick();
        set_src(1, 32'h0000_B7A1, 6'h06, 1'b0, 1'b1);
        push(6'h06, 32'h0000_B7A1, 1'b0, 1'b0);
        tick();
        src_valid = '0;
        repeat (3) tick();

        // Reset mid-operation discards held results without broadcasting.
        for (int i = 0; i < 4; i++)
            set_src(i, 32'hDEAD_0000 + 32'(i), 6'h2A + 6'(i), 1'b0, 1'b0);
        tick();
        src_valid = '0;
        rst = 1'b1;
        #1;
        chk("midrst_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("midrst_cdb_data", 64'(cdb_data), 64'd0);
        chk("midrst_cdb_tag", 64'(cdb_tag), 64'd0);
        chk("midrst_ready", 64'(src_ready), 64'hF);
        @(negedge clk) rst = 1'b0;
        repeat (6) tick();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, meaning the number of execution queues competing for the CDB (index 0 int, 1 ld/st, 2 mul, 3 div).
REQ-002 The block SHALL have parameter TAG_W, default 6, meaning the ROB/physical tag width.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high; ports are clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous mispredict flush; discards all pending results.
REQ-007 src_data  input  NUM_SRC*32  per-source result data; slice i is [32*i+31:32*i].
REQ-008 src_tag  input  NUM_SRC*TAG_W  per-source destination tag.
REQ-009 src_valid  input  NUM_SRC  per-source result-valid.
REQ-010 src_branch  input  NUM_SRC  per-source "result is a branch".
REQ-011 src_branch_taken  input  NUM_SRC  per-source branch outcome.
REQ-012 src_ready  output  NUM_SRC  per-source accept.
REQ-013 cdb_data  output  32  broadcast data.
REQ-014 cdb_tag  output  TAG_W  broadcast tag.
REQ-015 cdb_valid  output  1  broadcast valid, one cycle per result.
REQ-016 cdb_branch  output  1  broadcast is a branch.
REQ-017 cdb_branch_taken  output  1  branch outcome; SHALL be 0 whenever cdb_branch is 0.

Function
REQ-018 Each source SHALL own a 1-entry hold buffer (valid, data, tag, branch, taken).
REQ-019 src_ready[i] SHALL be combinational from registered state only: (!hold_valid[i] || grant[i]) && !flush.
REQ-020 A transfer SHALL occur at a rising edge where src_valid[i] && src_ready[i]; the hold buffer loads the source fields.
REQ-021 Each cycle, at most one hold buffer SHALL be granted, chosen round-robin: first valid index at or after rr_ptr, wrapping NUM_SRC-1 -> 0.
REQ-022 At the edge after a grant, the cdb_* outputs SHALL register the granted entry with cdb_valid=1, and rr_ptr SHALL become (granted index + 1) mod NUM_SRC.
REQ-023 If no hold buffer is valid, cdb_valid SHALL be 0 at the next edge; rr_ptr and cdb_data/cdb_tag SHALL hold their values.
REQ-024 Simultaneous grant and new transfer on the same source SHALL replace the buffer contents with the new result (no bubble); sustained throughput SHALL be one result per cycle.
REQ-025 Latency: a result transferred at edge k SHALL appear on the CDB no earlier than the cycle following edge k+1 and no later than the cycle following edge k+NUM_SRC.
REQ-026 Ungranted buffer contents SHALL remain stable until granted or flushed.
REQ-027 At an edge with flush=1, all hold_valid bits and cdb_valid SHALL clear, no transfer SHALL occur, and rr_ptr SHALL be retained.
REQ-028 src_valid while src_ready=0 SHALL NOT alter state; the source keeps its fields stable until accepted.

Reset
REQ-029 While rst=1, hold_valid SHALL be all 0, rr_ptr SHALL be 0, and cdb_valid, cdb_branch, cdb_branch_taken, cdb_data and cdb_tag SHALL be 0, independent of clk.
REQ-030 src_ready SHALL be all 1 in the first cycle after rst deasserts (flush=0).
REQ-031 Reset asserted mid-operation SHALL discard all held results with no broadcast.

Structure
REQ-032 NUM_SRC, TAG_W, DATA_W=32 and source indices SRC_INT=0, SRC_LS=1, SRC_MUL=2, SRC_DIV=3 SHALL live in the shared cobalt package.
REQ-033 The round-robin picker SHALL be a combinational sub-module rr_pick (inputs req vector and ptr; outputs one-hot grant and index).

Verification
REQ-034 Single source: src_valid[3]=1, data 0x0000_00A5, tag 6'h12 for one cycle after reset -> exactly one cdb_valid pulse, two edges later, with data 0xA5 and tag 0x12; src_ready[3] stays 1.
REQ-035 All four valid in the same cycle with tags 1,2,3,4, rr_ptr=0 -> CDB tags 1,2,3,4 on four consecutive cycles; rr_ptr ends at 0.
REQ-036 Source 2 is continuously valid with a new tag each cycle, others idle -> cdb_valid stays 1 every cycle; tags are in order with none lost or duplicated.
REQ-037 Fairness: sources 0 and 1 are continuously valid -> CDB alternates 0,1,0,1; neither source waits more than 2 cycles.
REQ-038 flush while sources 0 and 3 hold results -> cdb_valid=0 on the next cycle, neither tag is ever broadcast, and src_ready is 0 during flush.
REQ-039 Branch: src_branch[1]=1, taken=1 -> cdb_branch=1 and cdb_branch_taken=1; non-branch result with src_branch_taken[1]=1 -> cdb_branch_taken=0.
